// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller: state encoding,
// watchdog defaults and the Moore output decode.
package mult_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int MAX_STEPS_DEFAULT = 32;
    localparam int STEP_CNT_W        = 6;

    typedef struct packed {
        logic start_mult;
        logic multipliar;
        logic product;
        logic count;
        logic clear;
        logic busy;
        logic done;
        logic error;
    } ctrl_out_t;

    // Outputs depend only on the registered state (plus the latched watchdog flag).
    function automatic ctrl_out_t decode_outputs(input logic [1:0] state, input logic wd_fired);
        ctrl_out_t o;
        o = '0;
        case (state)
            ST_LOAD: begin
                o.clear      = 1'b1;
                o.start_mult = 1'b1;
                o.multipliar = 1'b1;
                o.busy       = 1'b1;
            end
            ST_STEP: begin
                o.product    = 1'b1;
                o.multipliar = 1'b1;
                o.count      = 1'b1;
                o.busy       = 1'b1;
            end
            ST_DONE: begin
                o.busy  = 1'b1;
                o.done  = 1'b1;
                o.error = wd_fired;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mult_control.sv
// Moore FSM sequencing the shift-add multiply datapath: LOAD, a run of STEP
// cycles ended by the datapath stop flag (or a watchdog), then a DONE pulse.
module mult_control
    import mult_ctrl_pkg::*;
#(
    parameter int MAX_STEPS = MAX_STEPS_DEFAULT
) (
    input  logic clock_sign,
    input  logic reset_sign,
    input  logic start_sign,
    input  logic stop,
    output logic start_mult_sign,
    output logic multipliar_sign,
    output logic product_sign,
    output logic count_sign,
    output logic clear_sign,
    output logic busy_sign,
    output logic done_sign,
    output logic error_sign
);

    localparam logic [STEP_CNT_W-1:0] WD_LIMIT = STEP_CNT_W'(MAX_STEPS);

    logic [1:0]            state;
    logic [1:0]            next_state;
    logic [STEP_CNT_W-1:0] step_cnt;
    logic                  wd_fired;
    logic                  wd_hit;
    ctrl_out_t             outs;

    // The step about to finish is number MAX_STEPS+1 when the count already equals MAX_STEPS.
    assign wd_hit = (step_cnt >= WD_LIMIT);

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: next_state = start_sign ? ST_LOAD : ST_IDLE;
            ST_LOAD: next_state = ST_STEP;
            ST_STEP: next_state = (stop || wd_hit) ? ST_DONE : ST_STEP;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_sign) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (reset_sign) begin
            state    <= ST_IDLE;
            step_cnt <= '0;
            wd_fired <= 1'b0;
        end else begin
            state    <= next_state;
            wd_fired <= (state == ST_STEP) && !stop && wd_hit;
            if (state == ST_LOAD) begin
                step_cnt <= '0;
            end else if (state == ST_STEP && step_cnt != '1) begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

    assign outs            = decode_outputs(state, wd_fired);
    assign start_mult_sign = outs.start_mult;
    assign multipliar_sign = outs.multipliar;
    assign product_sign    = outs.product;
    assign count_sign      = outs.count;
    assign clear_sign      = outs.clear;
    assign busy_sign       = outs.busy;
    assign done_sign       = outs.done;
    assign error_sign      = outs.error;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural shift-add datapath; expected
// completions are queued at start and checked when done_sign appears.
module tb_mult_control;

    logic clock_sign = 1'b0;
    logic reset_sign, start_sign, stop;
    logic start_mult_sign, multipliar_sign, product_sign, count_sign;
    logic clear_sign, busy_sign, done_sign, error_sign;

    mult_control dut (
        .clock_sign     (clock_sign),
        .reset_sign     (reset_sign),
        .start_sign     (start_sign),
        .stop           (stop),
        .start_mult_sign(start_mult_sign),
        .multipliar_sign(multipliar_sign),
        .product_sign   (product_sign),
        .count_sign     (count_sign),
        .clear_sign     (clear_sign),
        .busy_sign      (busy_sign),
        .done_sign      (done_sign),
        .error_sign     (error_sign)
    );

    always #5 clock_sign = ~clock_sign;

    localparam logic [7:0] OUT_IDLE = 8'h00;
    localparam logic [7:0] OUT_LOAD = 8'hCC;
    localparam logic [7:0] OUT_STEP = 8'h74;
    localparam logic [7:0] OUT_DONE = 8'h06;
    localparam logic [7:0] OUT_DERR = 8'h07;

    logic [7:0] outs;
    assign outs = {start_mult_sign, multipliar_sign, product_sign, count_sign,
                   clear_sign, busy_sign, done_sign, error_sign};

    // Datapath model: stop comes from its own counter unless a directed stop is selected.
    logic        use_dp, man_stop;
    logic [31:0] op_a, op_b, dp_mplier;
    logic [63:0] dp_prod;
    logic [4:0]  dp_cnt;
    assign stop = use_dp ? (dp_cnt == 5'd31) : man_stop;

    always_ff @(posedge clock_sign) begin
        if (clear_sign) begin
            dp_prod <= '0;
            dp_cnt  <= '0;
        end else begin
            if (product_sign && dp_mplier[0]) dp_prod <= dp_prod + ({32'b0, op_a} << dp_cnt);
            if (count_sign) dp_cnt <= dp_cnt + 5'd1;
        end
        if (multipliar_sign) dp_mplier <= start_mult_sign ? op_b : (dp_mplier >> 1);
    end

    int cyc = 0;
    int done_cnt = 0;
    always_ff @(posedge clock_sign) begin
        cyc <= cyc + 1;
        if (done_sign) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        int          due;
        logic        err;
        logic        chk_prod;
        logic [63:0] prod;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected completion for a start driven at this negedge (sampled at edge cyc+1).
    task automatic push_exp(input int lat, input logic err, input logic chk, input logic [63:0] prod);
        exp_t e;
        e.due      = cyc + 1 + lat;
        e.err      = err;
        e.chk_prod = chk;
        e.prod     = prod;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int   n;
        logic busy_ok;
        exp_t e;
        n       = 0;
        busy_ok = 1'b1;
        while (!done_sign && n < budget) begin
            if (!busy_sign) busy_ok = 1'b0;
            @(negedge clock_sign);
            n++;
        end
        if (!done_sign) begin
            check("done_timeout", 64'(done_sign), 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            check("unexpected_done", 64'(done_sign), 64'd0);
        end else begin
            e = sb.pop_front();
            check("done_cycle", 64'(cyc + 1), 64'(e.due));
            check("error_flag", 64'(error_sign), 64'(e.err));
            check("busy_held", 64'(busy_ok), 64'd1);
            check("done_outs", 64'(outs), 64'(e.err ? OUT_DERR : OUT_DONE));
            if (e.chk_prod) check("product", dp_prod, e.prod);
        end
    endtask

    initial begin
        int d0;
        reset_sign = 1'b1;
        start_sign = 1'b1;
        use_dp     = 1'b1;
        man_stop   = 1'b0;
        op_a       = '0;
        op_b       = '0;

        // Reset wins over a simultaneous start
        repeat (3) @(negedge clock_sign);
        check("reset_outs", 64'(outs), 64'(OUT_IDLE));
        start_sign = 1'b0;
        reset_sign = 1'b0;
        @(negedge clock_sign);
        check("idle_outs", 64'(outs), 64'(OUT_IDLE));

        // 7 x 9 with full latency and state output checks
        op_a = 32'd7; op_b = 32'd9;
        start_sign = 1'b1;
        push_exp(34, 1'b0, 1'b1, 64'd63);
        @(negedge clock_sign);
        start_sign = 1'b0;
        check("load_outs", 64'(outs), 64'(OUT_LOAD));
        @(negedge clock_sign);
        check("step_outs", 64'(outs), 64'(OUT_STEP));
        wait_done(40);
        @(negedge clock_sign);
        check("post_done_idle", 64'(outs), 64'(OUT_IDLE));

        // 0xFFFF x 0xFFFF with start pulses during STEP
        op_a = 32'hFFFF; op_b = 32'hFFFF;
        d0 = done_cnt;
        start_sign = 1'b1;
        push_exp(34, 1'b0, 1'b1, 64'hFFFE0001);
        @(negedge clock_sign);
        start_sign = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_sign);
            start_sign = i[0];
        end
        start_sign = 1'b0;
        wait_done(40);
        repeat (40) @(negedge clock_sign);
        check("single_done", 64'(done_cnt - d0), 64'd1);

        // stop ignored while IDLE
        use_dp   = 1'b0;
        man_stop = 1'b1;
        repeat (5) @(negedge clock_sign);
        check("idle_stop", 64'(outs), 64'(OUT_IDLE));

        // Watchdog: stop never asserted
        man_stop = 1'b0;
        start_sign = 1'b1;
        push_exp(35, 1'b1, 1'b0, 64'd0);
        @(negedge clock_sign);
        start_sign = 1'b0;
        wait_done(45);
        @(negedge clock_sign);
        check("wd_idle", 64'(outs), 64'(OUT_IDLE));

        // Reset in the 10th STEP cycle abandons the operation
        use_dp = 1'b1;
        op_a = 32'd5; op_b = 32'd6;
        start_sign = 1'b1;
        @(negedge clock_sign);
        start_sign = 1'b0;
        repeat (10) @(negedge clock_sign);
        check("step10_outs", 64'(outs), 64'(OUT_STEP));
        d0 = done_cnt;
        reset_sign = 1'b1;
        @(negedge clock_sign);
        reset_sign = 1'b0;
        check("abort_outs", 64'(outs), 64'(OUT_IDLE));
        repeat (40) @(negedge clock_sign);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // Fresh start after the abort
        op_a = 32'd3; op_b = 32'd5;
        start_sign = 1'b1;
        push_exp(34, 1'b0, 1'b1, 64'd15);
        @(negedge clock_sign);
        start_sign = 1'b0;
        wait_done(40);

        // Start held high: back-to-back operations 35 cycles apart
        repeat (3) @(negedge clock_sign);
        op_a = 32'h1234; op_b = 32'h10;
        start_sign = 1'b1;
        push_exp(34, 1'b0, 1'b1, 64'h12340);
        push_exp(69, 1'b0, 1'b1, 64'h12340);
        @(negedge clock_sign);
        wait_done(40);
        @(negedge clock_sign);
        check("b2b_idle", 64'(outs), 64'(OUT_IDLE));
        @(negedge clock_sign);
        check("b2b_load", 64'(outs), 64'(OUT_LOAD));
        start_sign = 1'b0;
        wait_done(40);
        @(negedge clock_sign);
        check("final_idle", 64'(outs), 64'(OUT_IDLE));
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter: MAX_STEPS, default 32, shift-add iterations per multiply (watchdog limit).
REQ-002 clock_sign  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_sign  input  1  reset, synchronous, active-high.
REQ-004 start_sign  input  1  request a multiply; sampled only in IDLE.
REQ-005 stop  input  1  datapath iteration counter reached final count (counter >= 31).
REQ-006 start_mult_sign  output  1  datapath multiplier mux selects raw multiplier operand.
REQ-007 multipliar_sign  output  1  multiplier register load enable.
REQ-008 product_sign  output  1  product register load enable.
REQ-009 count_sign  output  1  datapath iteration counter increment enable.
REQ-010 clear_sign  output  1  synchronous clear of datapath product register and iteration counter.
REQ-011 busy_sign  output  1  high in every state except IDLE.
REQ-012 done_sign  output  1  one-cycle pulse; result valid on datapath product_res/multipliar_res.
REQ-013 error_sign  output  1  one-cycle pulse with done_sign when watchdog fired.

Function
REQ-014 FSM states: IDLE, LOAD, STEP, DONE; Moore outputs, registered state.
REQ-015 IDLE: all outputs 0; start_sign=1 -> LOAD next edge; else stay.
REQ-016 LOAD (1 cycle): clear_sign=1, start_mult_sign=1, multipliar_sign=1, product_sign=0, count_sign=0; -> STEP unconditionally.
REQ-017 STEP: product_sign=1, multipliar_sign=1, count_sign=1, start_mult_sign=0, clear_sign=0.
REQ-018 STEP with stop=1 sampled: that cycle is the final step; -> DONE.
REQ-019 STEP with stop=0: stay in STEP, internal step count +1.
REQ-020 Internal 6-bit step counter: cleared in LOAD, increments each STEP cycle; saturates, never wraps.
REQ-021 Watchdog: step counter reaches MAX_STEPS+1 with stop still 0 -> DONE with error_sign=1.
REQ-022 Normal operation: stop first seen on 32nd STEP cycle (datapath counter 0..31), 32 steps total.
REQ-023 DONE (1 cycle): done_sign=1, all datapath enables 0; -> IDLE.
REQ-024 Latency: start_sign sampled at edge N -> LOAD in cycle N+1, STEP N+2..N+33, done_sign in cycle N+34.
REQ-025 start_sign while busy_sign=1: ignored, not queued.
REQ-026 start_sign held high continuously: new multiply begins in the cycle after DONE (back-to-back, IDLE lasts one cycle).
REQ-027 stop=1 during IDLE, LOAD or DONE: ignored.
REQ-028 Illegal state encoding: next state IDLE.

Reset
REQ-029 reset_sign=1 at a rising edge: state IDLE, step counter 0, all outputs 0 from the next cycle.
REQ-030 Reset mid-operation (LOAD/STEP/DONE): operation abandoned, no done_sign, no error_sign.
REQ-031 Reset has priority over start_sign in the same cycle.

Structure
REQ-032 Shared package mult_ctrl_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, STEP=2'd2, DONE=2'd3), MAX_STEPS default, step-counter width 6.
REQ-033 Single module, no sub-modules; instantiated beside the multiply datapath, outputs wired one-to-one to its control inputs.

Verification
REQ-034 Reset, then start_sign pulse; stop driven high on 32nd STEP cycle -> done_sign exactly at cycle N+34, error_sign=0, busy_sign high N+1..N+34.
REQ-035 Integrated with datapath: multiplicand 7, multiplier 9 -> product 63 at done_sign; 0xFFFF x 0xFFFF -> 0xFFFE0001.
REQ-036 start_sign pulsed repeatedly during STEP -> no restart, single done_sign at N+34.
REQ-037 stop held 0 forever -> done_sign and error_sign together after 33 STEP cycles, then IDLE.
REQ-038 reset_sign asserted in 10th STEP cycle -> IDLE next cycle, all outputs 0, no done_sign; fresh start completes normally.
REQ-039 start_sign held high across two operations -> second LOAD one cycle after first done_sign, two done_sign pulses 35 cycles apart.
